match_scanner: RTL
==================

// Module: match_scanner
// PURPOSE
//  Consumes the 32-bit match vector from the pattern matcher (bit i = pattern found at A[i+3:i])
//  and serialises it into a stream of match positions, lowest index first, one per accepted beat.
//  Sits directly downstream of the pattern-match stage in the MIPS ALU lab datapath.
//  Also reports the total match count and a one-cycle done pulse per scan.
// PARAMETERS
//  WIDTH     32  width of match_vec
//  VALID_POS 29  number of legal match positions; bits [WIDTH-1:VALID_POS] are forced to 0 on load
//  IDX_W     5   $clog2(WIDTH), width of out_index
//  CNT_W     6   $clog2(WIDTH)+1, width of match_count
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  start        in   1       load match_vec and begin a scan; honoured only in IDLE
//  abort        in   1       abandon the current scan; return to IDLE
//  match_vec    in   WIDTH   match vector from the pattern matcher
//  out_ready    in   1       downstream accepts out_index this cycle
//  out_valid    out  1       out_index holds a valid match position
//  out_index    out  IDX_W   lowest remaining set bit of the pending vector
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse when a scan completes normally
//  match_count  out  CNT_W   number of positions handed off in the current/last scan
// BEHAVIOUR
//  - Reset (async, any time, mid-scan included): state=IDLE, pending=0, match_count=0;
//    out_valid=0, out_index=0, busy=0, done=0. No partial results survive.
//  - Registers: state, pending[WIDTH-1:0], match_count. Outputs decode combinationally from registers only.
//  - States: IDLE -> SCAN -> DONE -> IDLE; IDLE -> DONE for an empty vector.
//  - IDLE: start=1 at edge n:
//      pending <= match_vec with bits >= VALID_POS cleared; match_count <= 0.
//      Masked vector != 0 -> SCAN; masked vector == 0 -> DONE.
//  - SCAN: pending is always nonzero. out_valid=1; out_index=index of lowest set bit of pending.
//      Handshake = out_valid & out_ready: clear that bit, match_count += 1.
//      If the cleared bit was the last one -> DONE on the same edge (no bubble).
//      Without a handshake, out_index and pending hold stable (no drop, no skip).
//  - DONE: done=1, out_valid=0 for exactly one cycle, then IDLE. start in DONE is ignored.
//  - match_count holds its final value in IDLE until the next accepted start.
//  - Latency: first out_valid in the cycle after the start edge; one index per cycle at full out_ready.
//    N matches finish with done in cycle n+1+N. Empty vector: done in cycle n+1.
//  - start outside IDLE: ignored, no effect on pending or count.
//  - abort (synchronous) in SCAN or DONE: -> IDLE next edge, pending <= 0, match_count holds, no done pulse.
//    Priority: abort > handshake > start. abort in IDLE has no effect.
//  - Max match_count = VALID_POS = 29; CNT_W cannot overflow.
// STRUCTURE
//  - Package match_pkg: typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;
//    localparams MATCH_W=32, MATCH_POS=29. The pattern matcher and this block both use them.
//  - Sub-module lowest_set_bit #(WIDTH): combinational priority encoder, inputs vec, outputs idx and any.
//    Used for out_index and for the last-bit test (pending & (pending-1)) == 0.
//  - Top: FSM, pending/count registers, handshake logic.
// TESTING
//  1 reset; start, match_vec=32'h0000_0011, out_ready=1 -> out_index 0 then 4 on consecutive cycles;
//    done in the next cycle; match_count=2.
//  2 match_vec=32'hE000_0000 (only illegal bits set) -> no out_valid; done in cycle after start; match_count=0.
//  3 match_vec=32'h1000_0001, out_ready=0 for 3 cycles -> out_index=0 held stable with out_valid=1;
//    then ready -> 0, 28, done; match_count=2.
//  4 match_vec=32'h1FFF_FFFF, out_ready=1 -> indices 0..28 in order, done, match_count=29;
//    start pulsed during SCAN is ignored.
//  5 match_vec=32'h0000_00F0; abort after 2 handshakes -> IDLE next cycle, no done, match_count=2.
//    Repeat and assert reset mid-scan -> all outputs 0 immediately.
//  6 Back-to-back scans: start in the cycle after done -> second scan runs correctly;
//    match_count restarts from 0.

Source files
------------

// File: rtl/match_pkg.sv
// -----------------------------------------------------------------------------
// match_pkg
//  Shared definitions for the pattern-match stage and the match scanner.
//  MATCH_W   : width of the match vector produced by the pattern matcher.
//  MATCH_POS : number of legal match positions (a 4-bit window needs A[i+3:i]).
//  scan_state_t : scanner FSM state encoding.
// -----------------------------------------------------------------------------
package match_pkg;

    localparam int MATCH_W   = 32;
    localparam int MATCH_POS = 29;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/match_scanner_lowest_set_bit.sv
// -----------------------------------------------------------------------------
// lowest_set_bit
//  Combinational priority encoder: index of the least-significant set bit.
//  Ports:
//    vec  in   WIDTH   input vector
//    idx  out  IDX_W   index of lowest set bit (0 when vec == 0)
//    any  out  1       vec has at least one bit set
// -----------------------------------------------------------------------------
module lowest_set_bit #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan high to low so the last assignment is the lowest set bit.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/match_scanner.sv
// -----------------------------------------------------------------------------
// match_scanner
//  Serialises the pattern matcher's match vector into a stream of match
//  positions, lowest index first, one per accepted out_valid/out_ready beat.
//  Reports the number of positions handed off and a one-cycle done pulse.
//  Ports:
//    clk          in   1      clock, rising edge
//    reset        in   1      asynchronous active-high reset
//    start        in   1      load match_vec and begin a scan (IDLE only)
//    abort        in   1      abandon current scan, back to IDLE
//    match_vec    in   WIDTH  match vector
//    out_ready    in   1      downstream accepts out_index
//    out_valid    out  1      out_index is a valid match position
//    out_index    out  IDX_W  lowest remaining set bit of pending vector
//    busy         out  1      state != IDLE
//    done         out  1      one-cycle pulse on normal scan completion
//    match_count  out  CNT_W  positions handed off in current/last scan
// -----------------------------------------------------------------------------
module match_scanner
    import match_pkg::*;
#(
    parameter int WIDTH     = MATCH_W,
    parameter int VALID_POS = MATCH_POS,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] match_vec,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);

    // Positions >= VALID_POS have no full 4-bit window behind them.
    localparam logic [WIDTH-1:0] VALID_MASK = {WIDTH{1'b1}} >> (WIDTH - VALID_POS);

    scan_state_t      state;
    logic [WIDTH-1:0] pending;

    logic [IDX_W-1:0] lsb_idx;
    logic             lsb_any;
    logic [WIDTH-1:0] pending_rest;
    logic [WIDTH-1:0] masked_vec;
    logic             handshake;
    logic             last_bit;

    lowest_set_bit #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lsb (
        .vec (pending),
        .idx (lsb_idx),
        .any (lsb_any)
    );

    // pending & (pending-1) drops the lowest set bit; zero means it was the last one.
    assign pending_rest = pending & (pending - WIDTH'(1));
    assign last_bit     = (pending_rest == '0);
    assign masked_vec   = match_vec & VALID_MASK;

    // pending is never empty in SCAN, so lsb_any only guards against an impossible state.
    assign out_valid = (state == S_SCAN) && lsb_any;
    assign out_index = out_valid ? lsb_idx : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= '0;
            match_count <= '0;
        end else if (abort && state != S_IDLE) begin
            // Abandon: count keeps what was already handed off, no done pulse.
            state   <= S_IDLE;
            pending <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending     <= masked_vec;
                        match_count <= '0;
                        state       <= (masked_vec != '0) ? S_SCAN : S_DONE;
                    end
                end
                S_SCAN: begin
                    if (handshake) begin
                        pending     <= pending_rest;
                        match_count <= match_count + CNT_W'(1);
                        if (last_bit) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

endmodule
